// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO burst reader: controller states, skid depth
// and the modulo-depth pointer increment used by the skid buffer.
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int SKID_DEPTH = 3;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(SKID_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Three-entry skid buffer absorbing the FIFO read latency; a word landing while
// the buffer is empty is presented directly so the first beat is not delayed.
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int data_width = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic [data_width-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [1:0]            occ_o,
    output logic                  avail_o,
    output logic [data_width-1:0] head_o
);

    logic [data_width-1:0] mem_q [SKID_DEPTH];
    logic [1:0]            wr_q;
    logic [1:0]            rd_q;
    logic [1:0]            occ_q;
    logic                  empty_s;
    logic                  store_s;
    logic                  adv_s;

    // Head selection and push/pop qualification, including the empty-buffer bypass
    always_comb begin
        empty_s = (occ_q == 2'd0);
        store_s = push_i & ~(empty_s & pop_i);
        adv_s   = pop_i & ~empty_s;
        avail_o = ~empty_s | push_i;
        if (!empty_s) begin
            head_o = mem_q[rd_q];
        end else if (push_i) begin
            head_o = push_data_i;
        end else begin
            head_o = {data_width{1'b0}};
        end
    end

    assign occ_o = occ_q;

    // Storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= {data_width{1'b0}};
            end
            wr_q  <= 2'd0;
            rd_q  <= 2'd0;
            occ_q <= 2'd0;
        end else begin
            if (store_s) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= ptr_inc(wr_q);
            end
            if (adv_s) begin
                rd_q <= ptr_inc(rd_q);
            end
            occ_q <= occ_q + 2'(push_i) - 2'(pop_i);
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst read controller draining a synchronous FIFO onto a valid/ready stream.
// Optional empty-FIFO abort is compiled in with FIFO_RD_TIMEOUT_EN.
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int data_width  = 32,
    parameter int burst_width = 4
`ifdef FIFO_RD_TIMEOUT_EN
    ,
    parameter int timeout_cycles = 16
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   EN,
    input  logic                   start,
    input  logic [burst_width-1:0] burst_len,
    output logic                   busy,
    input  logic                   fifo_empty,
    input  logic [data_width-1:0]  fifo_data,
    output logic                   fifo_rd_en,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [data_width-1:0]  m_data,
    output logic                   m_last,
    output logic [burst_width-1:0] beat_count
`ifdef FIFO_RD_TIMEOUT_EN
    ,
    output logic                   timeout
`endif
);

    state_t                 state_q, state_d;
    logic [burst_width-1:0] len_q, len_d;
    logic [burst_width-1:0] issued_q, issued_d;
    logic [burst_width-1:0] sent_q, sent_d;
    logic [burst_width-1:0] beat_q, beat_d;
    logic                   inflight_q;
    logic [1:0]             occ_s;
    logic                   avail_s;
    logic [data_width-1:0]  head_s;
    logic                   valid_s;
    logic                   pop_s;
    logic                   rd_en_s;
`ifdef FIFO_RD_TIMEOUT_EN
    localparam int TCNT_W = $clog2(timeout_cycles + 1);
    logic [TCNT_W-1:0]      tcnt_q, tcnt_d;
    logic                   timeout_q, timeout_d;
`endif

    fifo_rd_skid #(.data_width(data_width)) u_skid (
        .clk         (clk),
        .reset       (reset),
        .push_i      (inflight_q),
        .push_data_i (fifo_data),
        .pop_i       (pop_s),
        .occ_o       (occ_s),
        .avail_o     (avail_s),
        .head_o      (head_s)
    );

    // Reads are throttled on registered occupancy only, keeping m_ready off the rd_en path
    always_comb begin
        valid_s = avail_s & EN;
        pop_s   = valid_s & m_ready;
        rd_en_s = (state_q == READ) & EN & ~fifo_empty & (issued_q < len_q)
                & (({1'b0, occ_s} + {2'b00, inflight_q}) < 3'(SKID_DEPTH));
    end

    // Next-state and counter update
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        issued_d = issued_q + burst_width'(rd_en_s);
        sent_d   = sent_q + burst_width'(pop_s);
        beat_d   = beat_q + burst_width'(pop_s);
`ifdef FIFO_RD_TIMEOUT_EN
        tcnt_d    = tcnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start && EN && (burst_len != {burst_width{1'b0}})) begin
                    len_d    = burst_len;
                    issued_d = {burst_width{1'b0}};
                    sent_d   = {burst_width{1'b0}};
                    beat_d   = {burst_width{1'b0}};
                    state_d  = READ;
`ifdef FIFO_RD_TIMEOUT_EN
                    tcnt_d   = {TCNT_W{1'b0}};
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (issued_d == len_q) begin
                    state_d = DRAIN;
                end else begin
`ifdef FIFO_RD_TIMEOUT_EN
                    // Abort shrinks the burst to what was already read
                    if (EN && fifo_empty) begin
                        if (tcnt_q == TCNT_W'(timeout_cycles - 1)) begin
                            len_d     = issued_q;
                            timeout_d = 1'b1;
                            tcnt_d    = {TCNT_W{1'b0}};
                            state_d   = (issued_q == {burst_width{1'b0}}) ? IDLE : DRAIN;
                        end else begin
                            tcnt_d  = tcnt_q + TCNT_W'(1);
                            state_d = READ;
                        end
                    end else if (EN) begin
                        tcnt_d  = {TCNT_W{1'b0}};
                        state_d = READ;
                    end else begin
                        state_d = READ;
                    end
`else
                    state_d = READ;
`endif
                end
            end
            DRAIN: begin
                if (sent_d == issued_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            len_q      <= {burst_width{1'b0}};
            issued_q   <= {burst_width{1'b0}};
            sent_q     <= {burst_width{1'b0}};
            beat_q     <= {burst_width{1'b0}};
            inflight_q <= 1'b0;
`ifdef FIFO_RD_TIMEOUT_EN
            tcnt_q     <= {TCNT_W{1'b0}};
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            sent_q     <= sent_d;
            beat_q     <= beat_d;
            inflight_q <= rd_en_s;
`ifdef FIFO_RD_TIMEOUT_EN
            tcnt_q     <= tcnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign busy       = (state_q != IDLE);
    assign fifo_rd_en = rd_en_s;
    assign m_valid    = valid_s;
    assign m_data     = head_s;
    assign m_last     = valid_s & ((sent_q + burst_width'(1)) == issued_q) & (state_q == DRAIN);
    assign beat_count = beat_q;
`ifdef FIFO_RD_TIMEOUT_EN
    assign timeout    = timeout_q;
`endif

endmodule
